pixel_reorder_buffer: RTL and testbench

PIXEL_REORDER_BUFFER -- requirements
Module: pixel_reorder_buffer

---
 rtl/pixel_reorder_buffer.sv | 139 +++++++++++++
 tb/tb_pixel_reorder_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reorder_buffer.sv
// pixel_reorder_buffer
//
// Collects pixels from NUM_UNITS ray-tracing compute units, each with its own
// small FIFO, and emits them as one ordered stream: output pixel k of a frame
// always comes from unit (k mod NUM_UNITS). At the end of every frame the unit
// pointer restarts at unit 0, even if FRAME_PIXELS is not a multiple of
// NUM_UNITS.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high; valid and data are held by the source until accepted.
//
// Ports
//   aclk       in   clock, rising edge
//   areset     in   asynchronous active-high reset
//   in_data    in   NUM_UNITS*PIXEL_W, unit u at [u*PIXEL_W +: PIXEL_W]
//   in_valid   in   NUM_UNITS, per-unit pixel present
//   in_ready   out  NUM_UNITS, per-unit FIFO can accept this cycle
//   flush      in   synchronous clear of FIFOs, unit pointer and pixel counter
//   out_data   out  PIXEL_W, ordered pixel ({r,g,b}, r in MSBs)
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts
//   out_sof    out  first pixel of a frame (qualified by out_valid)
//   out_last   out  last pixel of a frame (qualified by out_valid)
//   occupancy  out  NUM_UNITS*4, per-unit FIFO fill count at [u*4 +: 4]
module pixel_reorder_buffer #(
    parameter int NUM_UNITS    = 4,
    parameter int PIXEL_W      = 24,
    parameter int DEPTH        = 2,
    parameter int FRAME_PIXELS = 640*480
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_UNITS*PIXEL_W-1:0] in_data,
    input  logic [NUM_UNITS-1:0]         in_valid,
    output logic [NUM_UNITS-1:0]         in_ready,
    input  logic                         flush,
    output logic [PIXEL_W-1:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sof,
    output logic                         out_last,
    output logic [NUM_UNITS*4-1:0]       occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SEL_W = $clog2(NUM_UNITS);
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_UNITS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);

    // FIFO storage is deliberately left out of reset; only pointers and
    // counts decide what is visible.
    logic [PIXEL_W-1:0] mem    [NUM_UNITS][DEPTH];
    logic [PTR_W-1:0]   rd_ptr [NUM_UNITS];
    logic [PTR_W-1:0]   wr_ptr [NUM_UNITS];
    logic [3:0]         count  [NUM_UNITS];

    logic [SEL_W-1:0]     sel;
    logic [PIX_W-1:0]     pix;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic                 xfer;
    logic [PIXEL_W-1:0]   head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // in_ready looks only at the registered count, so a full FIFO refuses a
    // push even in a cycle where it is being popped.
    always_comb begin
        in_ready  = '0;
        push      = '0;
        pop       = '0;
        occupancy = '0;
        head      = mem[sel][rd_ptr[sel]];
        out_valid = !flush && (count[sel] != 4'd0);
        xfer      = out_valid && out_ready;
        out_data  = out_valid ? head : '0;
        out_sof   = out_valid && (pix == '0);
        out_last  = out_valid && (pix == PIX_LAST);
        for (int u = 0; u < NUM_UNITS; u++) begin
            in_ready[u]         = !flush && (count[u] != DEPTH_C);
            push[u]             = in_valid[u] && in_ready[u];
            pop[u]              = xfer && (sel == SEL_W'(u));
            occupancy[u*4 +: 4] = count[u];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                count[u]  <= '0;
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
            end
            sel <= '0;
            pix <= '0;
        end else if (flush) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                count[u]  <= '0;
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
            end
            sel <= '0;
            pix <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (push[u]) wr_ptr[u] <= ptr_next(wr_ptr[u]);
                if (pop[u])  rd_ptr[u] <= ptr_next(rd_ptr[u]);
                case ({push[u], pop[u]})
                    2'b10:   count[u] <= count[u] + 4'd1;
                    2'b01:   count[u] <= count[u] - 4'd1;
                    default: count[u] <= count[u];
                endcase
            end
            if (xfer) begin
                // Frame wrap restarts the unit rotation at unit 0.
                if (pix == PIX_LAST) begin
                    pix <= '0;
                    sel <= '0;
                end else begin
                    pix <= pix + 1'b1;
                    sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (push[u]) mem[u][wr_ptr[u]] <= in_data[u*PIXEL_W +: PIXEL_W];
        end
    end

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// tb_pixel_reorder_buffer
//
// Drives pixel_reorder_buffer (4 units, depth 2, 6-pixel frames) with directed
// scenarios and randomized traffic. The reference model keeps one queue of
// pixels per unit plus the number of pixels already emitted in the current
// frame; the expected source unit of the next pixel is that index mod
// NUM_UNITS. Every cycle the model predicts in_ready, out_valid, out_data,
// out_sof, out_last and occupancy, then applies the cycle's transfers.
module tb_pixel_reorder_buffer;

    localparam int NU      = 4;
    localparam int PW      = 24;
    localparam int DEPTH   = 2;
    localparam int FRAME_N = 6;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [NU*PW-1:0] in_data = '0;
    logic [NU-1:0]   in_valid = '0;
    logic [NU-1:0]   in_ready;
    logic            flush = 1'b0;
    logic [PW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_sof;
    logic            out_last;
    logic [NU*4-1:0] occupancy;

    pixel_reorder_buffer #(
        .NUM_UNITS    (NU),
        .PIXEL_W      (PW),
        .DEPTH        (DEPTH),
        .FRAME_PIXELS (FRAME_N)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_last  (out_last),
        .occupancy (occupancy)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[NU][$];
    int            pix_m   = 0;
    int            n_check = 0;
    int            n_fail  = 0;
    int            n_xfer  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int u = 0; u < NU; u++) exp_q[u].delete();
        pix_m = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic [NU-1:0] vld, input logic ordy, input logic fl);
        logic [NU-1:0]   exp_rdy;
        logic [NU*4-1:0] exp_occ;
        logic            exp_vld;
        int              unit;
        in_valid  = vld;
        out_ready = ordy;
        flush     = fl;
        for (int u = 0; u < NU; u++) in_data[u*PW +: PW] = PW'($urandom);
        #3;
        unit = pix_m % NU;
        for (int u = 0; u < NU; u++) begin
            exp_rdy[u]        = !fl && (exp_q[u].size() != DEPTH);
            exp_occ[u*4 +: 4] = 4'(exp_q[u].size());
        end
        exp_vld = !fl && (exp_q[unit].size() != 0);
        check_eq("in_ready",  64'(in_ready),  64'(exp_rdy));
        check_eq("occupancy", 64'(occupancy), 64'(exp_occ));
        check_eq("out_valid", 64'(out_valid), 64'(exp_vld));
        check_eq("out_sof",   64'(out_sof),   64'(exp_vld && pix_m == 0));
        check_eq("out_last",  64'(out_last),  64'(exp_vld && pix_m == FRAME_N - 1));
        if (exp_vld) check_eq("out_data", 64'(out_data), 64'(exp_q[unit][0]));
        if (fl) begin
            model_clear();
        end else begin
            if (exp_vld && ordy) begin
                void'(exp_q[unit].pop_front());
                pix_m = (pix_m + 1) % FRAME_N;
                n_xfer++;
            end
            for (int u = 0; u < NU; u++)
                if (vld[u] && exp_rdy[u]) exp_q[u].push_back(in_data[u*PW +: PW]);
        end
        @(posedge aclk);
        #1;
    endtask

    // Asserts reset between edges and checks the outputs while it is held.
    task automatic do_reset();
        areset    = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = NU'($urandom);
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_sof",   64'(out_sof),   64'd0);
        check_eq("rst_out_last",  64'(out_last),  64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'({NU{1'b1}}));
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        in_valid = '0;
        areset   = 1'b0;
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PW-1:0] held;
        @(posedge aclk);
        #1;
        do_reset();

        // Units push in reverse order, drained in unit order.
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        repeat (5) step(4'b0000, 1'b1, 1'b0);

        // Unit 0 idle: other units fill up and stall, then unit 0 releases them.
        do_reset();
        repeat (3) step(4'b1110, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);

        // Output stall with a pixel at the head: data must hold.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        held = out_data;
        repeat (5) step(4'b0000, 1'b0, 1'b0);
        check_eq("stall_hold", 64'(out_data), 64'(held));
        step(4'b0000, 1'b1, 1'b0);

        // Continuous streaming across two frames of 6.
        do_reset();
        n_xfer = 0;
        repeat (16) step(4'b1111, 1'b1, 1'b0);
        check_eq("stream_xfers_ge12", 64'(n_xfer >= 12), 64'd1);

        // Full FIFO 0 selected: push refused while the pop happens.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        check_eq("full_pushpop_occ0", 64'(occupancy[3:0]), 64'd1);
        repeat (4) step(4'b0000, 1'b1, 1'b0);

        // Flush mid-frame with FIFOs partly filled.
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0110, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1010, 1'b0, 1'b1);
        check_eq("flush_occ", 64'(occupancy), 64'd0);
        step(4'b1110, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0);

        // Reset mid-frame with FIFOs partly filled.
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        do_reset();
        step(4'b1110, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0);

        // Randomized traffic, busy and congested downstream, rare flush/reset.
        for (int i = 0; i < 2000; i++) begin
            if (i % 700 == 699) do_reset();
            step(NU'($urandom),
                 (i < 1000) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2),
                 $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
